// File: rtl/alu_cmd_sequencer.sv
// Command FIFO and two-state sequencer that drives an external 32-bit ALU and
// writes its result back into an accumulator, one command every two cycles.
module alu_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [31:0] cmd_data,
  input  logic        cmd_clear,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [3:0]  alu_opcode,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic [31:0] acc,
  output logic        acc_zero,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic {IDLE, EXEC} state_t;

  typedef struct packed {
    logic        clear;
    logic [3:0]  op;
    logic [31:0] data;
  } cmd_t;

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(FIFO_DEPTH);

  cmd_t             mem [FIFO_DEPTH];
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  state_t           state, state_nxt;
  logic             push, pop;
  logic             exec_clear;

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
      4'b1000, 4'b1001, 4'b1010, 4'b1101: is_legal = 1'b1;
      default:                            is_legal = 1'b0;
    endcase
  endfunction

  assign cmd_ready = (count != FULL);
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr];

  // NOTE: the storage array has no reset; count guards every read, so stale
  // entries are never observed and the array can map onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{clear: cmd_clear, op: cmd_op, data: cmd_data};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count != '0) state_nxt = EXEC;
      EXEC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop  = 1'b0;
    busy = 1'b0;
    pop  = (state == IDLE) && (count != '0);
    busy = (state != IDLE) || (count != '0);
  end

  // Operand launch on pop, result write-back at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_opcode <= 4'b0000;
      exec_clear <= 1'b0;
      acc        <= '0;
      acc_zero   <= 1'b1;
      err        <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (pop) begin
        alu_op1    <= acc;
        alu_op2    <= head.data;
        alu_opcode <= head.clear ? 4'b0000 : head.op;
        exec_clear <= head.clear;
      end
      if (state == EXEC) begin
        done <= 1'b1;
        if (exec_clear) begin
          acc      <= '0;
          acc_zero <= 1'b1;
          err      <= 1'b0;
        end else if (is_legal(alu_opcode)) begin
          acc      <= alu_result;
          acc_zero <= alu_zero;
        end else begin
          err      <= 1'b1;
        end
      end
    end
  end

endmodule
